// File: rtl/bfloat_pkg.sv
// Shared bfloat16 types and constants for the add/sub controller
// and the MAC datapath blocks that reuse the classifier.
package bfloat_pkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } bf16_class_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } ctrl_state_e;

    localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
    localparam logic [15:0] BF16_QNAN    = 16'hFFFF;
    localparam logic [15:0] BF16_POS_INF = 16'h7F80;
    localparam logic [15:0] BF16_NEG_INF = 16'hFF80;

endpackage

// File: rtl/bfloat_classify.sv
// Combinational bfloat16 class decode; subnormals count as zero,
// matching the flush-to-zero behaviour of the add/sub unit.
module bfloat_classify
    import bfloat_pkg::*;
(
    input  bf16_t       x_i,
    output bf16_class_t cls_o
);

    logic unused_sign;
    assign unused_sign = x_i.sign;

    always_comb begin
        cls_o = '0;
        if (x_i.exp == BF16_EXP_MAX) begin
            cls_o.nan = (x_i.mant != '0);
            cls_o.inf = (x_i.mant == '0);
        end
        cls_o.zero = (x_i.exp == 8'h00);
    end

endmodule

// File: rtl/bfloat_add_sub_ctrl.sv
// Request/response wrapper that hides the fixed latency of the
// bfloat16 add/sub unit behind valid/ready handshakes.
module bfloat_add_sub_ctrl
    import bfloat_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [15:0]      req_a,
    input  logic [15:0]      req_b,
    input  logic             req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic [15:0]      au_a,
    output logic [15:0]      au_b,
    output logic             au_cntl,
    input  logic [15:0]      au_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_c,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_nan,
    output logic             rsp_inf,
    output logic             rsp_zero,
    output logic             busy
);

    localparam int CNT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;

    ctrl_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      au_a_q;
    logic [15:0]      au_b_q;
    logic             au_cntl_q;
    logic [TAG_W-1:0] tag_q;
    logic [15:0]      rsp_c_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic             rsp_valid_q;
    bf16_class_t      cls_q;
    bf16_class_t      cls_c;
    logic             accept;

    bfloat_classify u_classify (
        .x_i   (bf16_t'(au_c)),
        .cls_o (cls_c)
    );

    assign req_ready = (state_q == IDLE) ||
                       ((state_q == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;

    // Accept can only happen from IDLE or RESP, so it takes priority
    // over the per-state updates and also retires a pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            au_a_q      <= '0;
            au_b_q      <= '0;
            au_cntl_q   <= 1'b0;
            tag_q       <= '0;
            rsp_c_q     <= '0;
            rsp_tag_q   <= '0;
            rsp_valid_q <= 1'b0;
            cls_q       <= '0;
        end else if (accept) begin
            au_a_q      <= req_a;
            au_b_q      <= req_b;
            au_cntl_q   <= req_op;
            tag_q       <= req_tag;
            cnt_q       <= CNT_W'(LAT);
            rsp_valid_q <= 1'b0;
            state_q     <= WAIT;
        end else begin
            unique case (state_q)
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rsp_c_q     <= au_c;
                        rsp_tag_q   <= tag_q;
                        cls_q       <= cls_c;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign au_a      = au_a_q;
    assign au_b      = au_b_q;
    assign au_cntl   = au_cntl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_nan   = cls_q.nan;
    assign rsp_inf   = cls_q.inf;
    assign rsp_zero  = cls_q.zero;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bfloat_add_sub_ctrl.sv
// Scoreboard bench for bfloat_add_sub_ctrl with a behavioural
// one-cycle bfloat16 add/sub unit attached to the au_* port.
module tb_bfloat_add_sub_ctrl;

    localparam int LAT   = 1;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [15:0]      req_a;
    logic [15:0]      req_b;
    logic             req_op;
    logic [TAG_W-1:0] req_tag;
    logic [15:0]      au_a;
    logic [15:0]      au_b;
    logic             au_cntl;
    logic [15:0]      au_c;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_c;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_nan;
    logic             rsp_inf;
    logic             rsp_zero;
    logic             busy;

    typedef struct {
        logic [15:0]      c;
        logic [TAG_W-1:0] tag;
        int               acc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   prev_v = 1'b0;
    bit   stream = 1'b0;
    int   last_rsp = -1;

    bfloat_add_sub_ctrl #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .req_tag   (req_tag),
        .au_a      (au_a),
        .au_b      (au_b),
        .au_cntl   (au_cntl),
        .au_c      (au_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_tag   (rsp_tag),
        .rsp_nan   (rsp_nan),
        .rsp_inf   (rsp_inf),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real bf_val(logic [15:0] x);
        real v;
        int  e;
        e = int'(x[14:7]);
        if (e == 0) return 0.0;
        v = 1.0 + real'(x[6:0]) / 128.0;
        while (e > 127) begin v = v * 2.0; e--; end
        while (e < 127) begin v = v / 2.0; e++; end
        return x[15] ? -v : v;
    endfunction

    // Reference add/sub: exact sum, truncated to bf16, FTZ, NaN = FFFF.
    function automatic logic [15:0] bf_model(logic [15:0] a,
                                             logic [15:0] b,
                                             logic op);
        logic [15:0] bb;
        real         r;
        logic        s;
        int          e;
        int          m;
        bb = op ? (b ^ 16'h8000) : b;
        if ((a[14:7] == 8'hFF && a[6:0] != 0) ||
            (bb[14:7] == 8'hFF && bb[6:0] != 0)) return 16'hFFFF;
        if (a[14:7] == 8'hFF && bb[14:7] == 8'hFF)
            return (a[15] != bb[15]) ? 16'hFFFF : a;
        if (a[14:7] == 8'hFF) return a;
        if (bb[14:7] == 8'hFF) return bb;
        r = bf_val(a) + bf_val(bb);
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        if (s) r = -r;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        if (e >= 255) return {s, 8'hFF, 7'h00};
        if (e <= 0) return {s, 15'h0000};
        m = $rtoi((r - 1.0) * 128.0);
        return {s, e[7:0], m[6:0]};
    endfunction

    always @(posedge clk) au_c <= bf_model(au_a, au_b, au_cntl);

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic chk_resp(exp_t e);
        logic exp_nan;
        logic exp_inf;
        logic exp_zero;
        exp_nan  = (e.c[14:7] == 8'hFF) && (e.c[6:0] != 7'h0);
        exp_inf  = (e.c[14:7] == 8'hFF) && (e.c[6:0] == 7'h0);
        exp_zero = (e.c[14:7] == 8'h00);
        chk("rsp_c", 32'(rsp_c), 32'(e.c));
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_nan", 32'(rsp_nan), 32'(exp_nan));
        chk("rsp_inf", 32'(rsp_inf), 32'(exp_inf));
        chk("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
    endtask

    // Monitor: a rising rsp_valid pops one expectation; held cycles
    // must keep presenting the same response.
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else if (rsp_valid && !prev_v) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_c), 32'hDEAD);
            end else begin
                cur = q.pop_front();
                chk_resp(cur);
                chk("latency", 32'(cyc), 32'(cur.acc + LAT + 2));
                if (stream && last_rsp >= 0)
                    chk("interval", 32'(cyc - last_rsp), 32'(LAT + 2));
                last_rsp = cyc;
            end
            prev_v = 1'b1;
        end else if (rsp_valid) begin
            chk_resp(cur);
        end else begin
            prev_v = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accept edge.
    task automatic send(logic [15:0] a, logic [15:0] b, logic op,
                        logic [TAG_W-1:0] tag, logic [15:0] c, bit push);
        exp_t e;
        bit   done;
        done = 1'b0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_op = op;
        req_tag = tag;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                e.c = c;
                e.tag = tag;
                e.acc = cyc;
                if (push) q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_c", 32'(rsp_c), 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_flags", 32'({rsp_nan, rsp_inf, rsp_zero}), 32'd0);
        chk("rst_au", 32'({au_cntl, au_a, au_b}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rop;
        rst = 1'b1;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        req_op = 1'b0;
        req_tag = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state();
        @(posedge clk);
        #1;

        send(16'hFF86, 16'h7F83, 1'b0, 4'h1, 16'hFFFF, 1'b1);
        wait_idle();
        send(16'h7F80, 16'h7F80, 1'b0, 4'h5, 16'h7F80, 1'b1);
        wait_idle();
        send(16'h0000, 16'h7F80, 1'b1, 4'h6, 16'hFF80, 1'b1);
        wait_idle();
        send(16'h40D0, 16'h40B0, 1'b0, 4'h7, 16'h4140, 1'b1);
        wait_idle();
        send(16'h40D0, 16'h40D0, 1'b1, 4'h8, 16'h0000, 1'b1);
        wait_idle();

        rsp_ready = 1'b0;
        send(16'h3F80, 16'h4000, 1'b0, 4'h3, 16'h4040, 1'b1);
        for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        send(16'h4100, 16'h3F80, 1'b1, 4'h9, 16'h40E0, 1'b1);
        @(negedge clk);
        chk("bp_retired", 32'(rsp_valid), 32'd0);
        wait_idle();

        send(16'h4000, 16'h4000, 1'b0, 4'hA, 16'h4080, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state();
        repeat (6) @(negedge clk);
        chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        stream = 1'b1;
        last_rsp = -1;
        for (int i = 0; i < 8; i++) begin
            ra = {1'($urandom), 8'($urandom_range(135, 120)), 7'($urandom)};
            rb = {1'($urandom), 8'($urandom_range(135, 120)), 7'($urandom)};
            rop = 1'($urandom);
            send(ra, rb, rop, 4'(i + 2), bf_model(ra, rb, rop), 1'b1);
        end
        wait_idle();
        stream = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bfloat_add_sub_ctrl.md
Name: bfloat_add_sub_ctrl

Overview:
- Request/response controller that sits on the operand side of the bfloat16 add/sub unit.
- Accepts operand requests over a valid/ready interface and drives the unit's a/b/cntl inputs.
- Waits the unit's fixed latency, then captures c and returns it with a tag and decoded class flags over a valid/ready response interface.
- Lets the MAC datapath and the software-visible wrappers use the adder without knowing its latency.

Parameters:
LAT, 1, clock edges between the unit sampling a/b/cntl and c becoming valid (0 = combinational unit)
TAG_W, 4, width of the request/response tag

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_a  in  16  bfloat16 operand a
req_b  in  16  bfloat16 operand b
req_op  in  1  0 = add, 1 = subtract (a - b)
req_tag  in  TAG_W  opaque tag, returned with the response
au_a  out  16  to add/sub unit a
au_b  out  16  to add/sub unit b
au_cntl  out  1  to add/sub unit cntl
au_c  in  16  from add/sub unit c
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_c  out  16  captured result
rsp_tag  out  TAG_W  tag of the originating request
rsp_nan  out  1  rsp_c exponent = 0xFF and mantissa != 0
rsp_inf  out  1  rsp_c exponent = 0xFF and mantissa = 0
rsp_zero  out  1  rsp_c exponent = 0 (subnormals flushed, matching the unit)
busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-high): state = IDLE, cnt = 0, all registered outputs = 0 (au_*, rsp_*, flags).
  - Reset mid-WAIT or mid-RESP discards the transaction; no response is ever produced for it.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE) || (state == RESP && rsp_ready). This is combinational from rsp_ready and permitted.
- Accept means req_valid && req_ready at a rising edge E0. On accept:
  - au_a <= req_a, au_b <= req_b, au_cntl <= req_op;
  - tag register <= req_tag;
  - cnt <= LAT; state <= WAIT.
- au_a/au_b/au_cntl hold their value until the next accept; they do not change in WAIT or RESP.
- WAIT:
  - On each edge with cnt != 0: cnt <= cnt - 1.
  - On the edge with cnt == 0: rsp_c <= au_c, rsp_tag <= tag, flags <= classify(au_c), rsp_valid <= 1, state <= RESP.
  - Capture therefore occurs at edge E0+LAT+1; rsp_valid is visible after that edge.
  - req_valid is ignored in WAIT.
- RESP:
  - rsp_valid = 1 and rsp_c/rsp_tag/flags are held stable while rsp_ready = 0.
  - rsp_ready = 1 and req_valid = 0: rsp_valid <= 0, state <= IDLE.
  - rsp_ready = 1 and req_valid = 1: response retires and the new request is accepted on the same edge (accept rules above; state <= WAIT, rsp_valid <= 0).
- Flags are mutually exclusive and registered with rsp_c. The sign bit is not decoded; consumers read rsp_c[15].
- cnt width is $clog2(LAT+1), minimum 1. LAT = 0 is legal (capture at E0+1).
- Throughput: one result per LAT+2 cycles with back-to-back requests and rsp_ready held high.
- No arithmetic is performed in this block; the result is exactly au_c.

Decomposition:
- bfloat_pkg (shared package):
  - typedef bf16_t: packed struct {sign, exp[7:0], mant[6:0]}.
  - Constants: BF16_EXP_MAX = 8'hFF, BF16_QNAN = 16'hFFFF (the unit's NaN output), BF16_POS_INF = 16'h7F80, BF16_NEG_INF = 16'hFF80.
  - ctrl_state_e enum {IDLE, WAIT, RESP}.
  - bf16_class_t struct {nan, inf, zero}.
- One sub-module: bfloat_classify, combinational, bf16_t in -> bf16_class_t out. It is reused later by the MAC accumulator.

Test Plan:
All scenarios use LAT = 1 with a real bfloat_add_sub instance wired to au_*.
- NaN: req_a = 0xFF86, req_b = 0x7F83, op = 0 -> rsp_c = 0xFFFF, rsp_nan = 1, rsp_inf = rsp_zero = 0; rsp_valid first seen high after edge E0+2.
- Infinity and tag: 0x7F80 + 0x7F80, op = 0, tag = 0x5 -> rsp_c = 0x7F80, rsp_inf = 1, rsp_tag = 0x5. Then 0x0000 - 0x7F80, op = 1 -> rsp_c = 0xFF80, rsp_inf = 1.
- Arithmetic: 0x40D0 + 0x40B0 (6.5 + 5.5) -> 0x4140 (12.0), all flags 0. 0x40D0 - 0x40D0 -> 0x0000, rsp_zero = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_c, rsp_tag and flags unchanged; req_ready = 0, busy = 1. Then raise rsp_ready with req_valid = 1 -> retire and accept on the same edge; the next response is correct with the new tag.
- Reset mid-op: assert rst for one cycle the cycle after accept -> state IDLE, rsp_valid never rises for that request, all outputs 0, req_ready = 1 on the next cycle.
- Back-to-back stream: 8 random requests with rsp_ready tied high -> responses in order, tags matched, interval exactly 3 cycles, each rsp_c matching a scoreboard of the unit's output.
